fp_stft4_bin_serializer: RTL and testbench
==========================================

Name: fp_stft4_bin_serializer

Overview:
Downstream stage of the 4-point floating-point STFT top. Captures each completed 4-bin spectrum (re/im X0..X3, IEEE-754 single) on the STFT valid_out pulse. Holds captured spectra in a two-frame ping-pong buffer. Streams them one bin per beat over a valid/ready interface, tagged with bin index, last-bin flag and frame sequence number. The interface feeds the spectrogram writer and the UART/DMA path.

Parameters:
DW, 32, data word width per real/imag component (IEEE-754 single)
FCNT_W, 8, width of the emitted-frame sequence counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  one-cycle pulse: bin inputs hold a complete spectrum this cycle
re_X0..re_X3  input  DW each  real parts of bins 0..3
im_X0..im_X3  input  DW each  imaginary parts of bins 0..3
ready_in  input  1  downstream can accept a beat this cycle
valid_out  output  1  beat on re_out/im_out is valid
re_out  output  DW  real part of current bin
im_out  output  DW  imaginary part of current bin
bin_idx  output  2  index of current bin, 0..3
last  output  1  high with bin_idx==3 while valid_out
frame_seq  output  FCNT_W  sequence number of frame being emitted
overflow  output  1  sticky: a frame was dropped because both slots were full
drop_pulse  output  1  one-cycle pulse on each dropped frame

Behaviour:
- Reset (async, rst_n=0): valid_out=0, re_out=0, im_out=0, bin_idx=0, last=0, frame_seq=0, overflow=0, drop_pulse=0.
- Reset also clears the write pointer, read pointer and occupancy count to 0, and clears both slots to 0.
- Reset mid-stream drops all buffered frames. valid_out falls immediately, without waiting for a clock edge.
- Storage: two slots, each holding 4 x (re, im). The 1-bit write pointer wp and 1-bit read pointer rp toggle independently. Occupancy cnt is 0..2.
- Capture: on an edge with valid_in=1 and cnt<2, all 8 words are stored into slot wp, wp toggles, and cnt increments.
- Drop: on an edge with valid_in=1 and cnt==2 at the start of the cycle, the frame is discarded, drop_pulse=1 for the next cycle, and overflow=1 until reset.
- A drop still occurs when the last beat of the oldest frame transfers in the same cycle. There is no same-cycle slot reuse.
- Output FSM has two states:
  - IDLE (cnt==0): valid_out=0.
  - SEND (cnt>0): valid_out=1, re_out/im_out = slot[rp][bin_idx].
- A beat transfers on an edge where valid_out && ready_in.
- On transfer with bin_idx<3: bin_idx increments.
- On transfer with bin_idx==3:
  - bin_idx returns to 0, rp toggles, cnt decrements, and frame_seq increments (wraps 2^FCNT_W-1 -> 0).
  - The FSM returns to IDLE if cnt becomes 0; otherwise it stays in SEND with no bubble.
- Simultaneous capture and final-beat transfer with cnt==1: cnt stays 1. The new frame is emitted starting the next cycle.
- Latency: a frame captured at edge N presents bin 0 with valid_out=1 in cycle N+1 when cnt was 0. Otherwise it starts directly after the preceding frame's last beat.
- Backpressure: while valid_out=1 and ready_in=0, re_out, im_out, bin_idx, last and frame_seq hold stable.
- Output data is selected combinationally from registered storage and pointers; there is no combinational path from valid_in to any output.
- Data is passed bit-exact. No arithmetic is performed on the FP words; NaN/Inf/denormal patterns pass through unchanged.
- last = valid_out && (bin_idx==3).

Test Plan:
- Single frame, ready_in=1, X0..X3 re = 3F800000/40000000/40400000/40800000, im = 0/BF800000/0/3F800000 -> four consecutive beats bin_idx 0..3 with matching words, last only on beat 3, frame_seq=0, then valid_out=0; afterwards frame_seq=1.
- Backpressure: same frame with ready_in toggling 1,0,0,1,1,0,1 -> each bin emitted exactly once, in order; outputs stable during ready_in=0 cycles; 4 transfers total.
- Overflow: ready_in=0, three valid_in pulses with re_X0=1,2,3 -> third frame dropped, drop_pulse one cycle, overflow=1. Releasing ready_in emits frames 1 then 2 with back-to-back last/bin0 and no gap, frame_seq 0 then 1.
- Boundary: cnt==1, last beat transfers in the same cycle as a new valid_in -> no drop; the new frame's bin 0 appears the next cycle. With cnt==2 in the same situation -> the frame is dropped.
- Wrap: emit 256 frames -> frame_seq runs 0..255, then shows 0 on frame 257.
- Reset mid-frame: assert rst_n=0 asynchronously after beat 1 of a frame with a second frame queued -> valid_out=0 before the next edge, overflow=0. After release, a new frame starts at bin_idx=0 with frame_seq=0.

Source files
------------

// File: rtl/fp_stft4_bin_serializer.sv
// Ping-pong buffer for 4-bin STFT spectra, streamed one bin per beat over valid/ready.
// Each beat carries the bin index, a last-bin flag and the frame sequence number.
module fp_stft4_bin_serializer #(
    parameter int unsigned DW     = 32,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DW-1:0]     re_X0,
    input  logic [DW-1:0]     re_X1,
    input  logic [DW-1:0]     re_X2,
    input  logic [DW-1:0]     re_X3,
    input  logic [DW-1:0]     im_X0,
    input  logic [DW-1:0]     im_X1,
    input  logic [DW-1:0]     im_X2,
    input  logic [DW-1:0]     im_X3,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DW-1:0]     re_out,
    output logic [DW-1:0]     im_out,
    output logic [1:0]        bin_idx,
    output logic              last,
    output logic [FCNT_W-1:0] frame_seq,
    output logic              overflow,
    output logic              drop_pulse
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     re_mem [2][4];
    logic [DW-1:0]     im_mem [2][4];
    logic [DW-1:0]     re_in  [4];
    logic [DW-1:0]     im_in  [4];
    logic              wp_q, rp_q;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        bin_q;
    logic [FCNT_W-1:0] seq_q;
    logic              ovf_q, drop_q;
    logic              cap, drop, xfer, fin;

    assign re_in[0] = re_X0;
    assign re_in[1] = re_X1;
    assign re_in[2] = re_X2;
    assign re_in[3] = re_X3;
    assign im_in[0] = im_X0;
    assign im_in[1] = im_X1;
    assign im_in[2] = im_X2;
    assign im_in[3] = im_X3;

    // Drop decision uses occupancy at the start of the cycle: no same-cycle slot reuse.
    always_comb begin
        cap     = valid_in && (cnt_q != 2'd2);
        drop    = valid_in && (cnt_q == 2'd2);
        xfer    = (state_q == StSend) && ready_in;
        fin     = xfer && (bin_q == 2'd3);
        cnt_d   = cnt_q;
        state_d = state_q;
        case ({cap, fin})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        case (state_q)
            StIdle:  state_d = (cnt_d != 2'd0) ? StSend : StIdle;
            StSend:  state_d = (cnt_d != 2'd0) ? StSend : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            cnt_q   <= 2'd0;
            bin_q   <= 2'd0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop;
            if (drop) ovf_q <= 1'b1;
            if (cap)  wp_q  <= ~wp_q;
            if (xfer) bin_q <= bin_q + 2'd1;
            if (fin) begin
                rp_q  <= ~rp_q;
                seq_q <= seq_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int b = 0; b < 4; b++) begin
                    re_mem[s][b] <= '0;
                    im_mem[s][b] <= '0;
                end
            end
        end else if (cap) begin
            for (int b = 0; b < 4; b++) begin
                re_mem[wp_q][b] <= re_in[b];
                im_mem[wp_q][b] <= im_in[b];
            end
        end
    end

    always_comb begin
        valid_out  = (state_q == StSend);
        re_out     = valid_out ? re_mem[rp_q][bin_q] : '0;
        im_out     = valid_out ? im_mem[rp_q][bin_q] : '0;
        bin_idx    = bin_q;
        last       = valid_out && (bin_q == 2'd3);
        frame_seq  = seq_q;
        overflow   = ovf_q;
        drop_pulse = drop_q;
    end

endmodule

// File: tb/tb_fp_stft4_bin_serializer.sv
// Bench for fp_stft4_bin_serializer: directed and random traffic against a
// frame-queue reference model.
module tb_fp_stft4_bin_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] re_in [4];
    logic [31:0] im_in [4];
    logic        valid_out;
    logic [31:0] re_out, im_out;
    logic [1:0]  bin_idx;
    logic        last;
    logic [7:0]  frame_seq;
    logic        overflow, drop_pulse;

    always #5 clk = ~clk;

    fp_stft4_bin_serializer #(.DW(32), .FCNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .re_X0      (re_in[0]),
        .re_X1      (re_in[1]),
        .re_X2      (re_in[2]),
        .re_X3      (re_in[3]),
        .im_X0      (im_in[0]),
        .im_X1      (im_in[1]),
        .im_X2      (im_in[2]),
        .im_X3      (im_in[3]),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .re_out     (re_out),
        .im_out     (im_out),
        .bin_idx    (bin_idx),
        .last       (last),
        .frame_seq  (frame_seq),
        .overflow   (overflow),
        .drop_pulse (drop_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a FIFO of whole frames, at most two deep.
    typedef struct packed {
        logic [3:0][31:0] re;
        logic [3:0][31:0] im;
    } frame_t;

    frame_t q[$];
    int     m_beat;
    int     m_frames_sent;
    bit     m_ovf;
    bit     m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_beat        = 0;
        m_frames_sent = 0;
        m_ovf         = 0;
        m_drop        = 0;
    endtask

    task automatic set_frame(input logic [31:0] r0, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] r3,
                             input logic [31:0] i0, input logic [31:0] i1,
                             input logic [31:0] i2, input logic [31:0] i3);
        re_in[0] = r0; re_in[1] = r1; re_in[2] = r2; re_in[3] = r3;
        im_in[0] = i0; im_in[1] = i1; im_in[2] = i2; im_in[3] = i3;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 4; i++) begin
            re_in[i] = $urandom;
            im_in[i] = $urandom;
        end
    endtask

    task automatic compare_outputs();
        bit          ev;
        logic [31:0] exp_seq;
        ev      = (q.size() > 0);
        exp_seq = m_frames_sent % 256;
        check("valid_out", 64'(valid_out), 64'(ev));
        check("last", 64'(last), 64'(ev && m_beat == 3));
        check("bin_idx", 64'(bin_idx), 64'(m_beat));
        check("frame_seq", 64'(frame_seq), 64'(exp_seq[7:0]));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_pulse", 64'(drop_pulse), 64'(m_drop));
        if (ev) begin
            check("re_out", 64'(re_out), 64'(q[0].re[m_beat]));
            check("im_out", 64'(im_out), 64'(q[0].im[m_beat]));
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, then advance model at the edge.
    task automatic cycle(input logic v, input logic r);
        frame_t f;
        int     pre;
        bit     ev;
        valid_in = v;
        ready_in = r;
        for (int i = 0; i < 4; i++) begin
            f.re[i] = re_in[i];
            f.im[i] = im_in[i];
        end
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        pre    = q.size();
        ev     = (pre > 0);
        m_drop = v && (pre == 2);
        if (m_drop) m_ovf = 1;
        if (ev && r) begin
            if (m_beat == 3) begin
                void'(q.pop_front());
                m_beat = 0;
                m_frames_sent++;
            end else begin
                m_beat++;
            end
        end
        if (v && pre < 2) q.push_back(f);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(1'b0, r);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        rand_frame();
        model_reset();
        #3;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_re_out", 64'(re_out), 64'd0);
        check("rst_im_out", 64'(im_out), 64'd0);
        check("rst_bin_idx", 64'(bin_idx), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_frame_seq", 64'(frame_seq), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_pulse", 64'(drop_pulse), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, always ready.
        set_frame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h00000000, 32'hBF800000, 32'h00000000, 32'h3F800000);
        cycle(1'b1, 1'b1);
        idle(6, 1'b1);
        check("seq_after_single", 64'(frame_seq), 64'd1);

        // Backpressure pattern 1,0,0,1,1,0,1.
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1);
        idle(2, 1'b1);

        // Overflow: three frames into a stalled output, third dropped.
        for (int k = 1; k <= 3; k++) begin
            rand_frame();
            re_in[0] = k;
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        idle(2, 1'b0);
        idle(10, 1'b1);

        // cnt==1: final beat and new capture together -> no drop.
        rand_frame(); cycle(1'b1, 1'b1);
        idle(3, 1'b1);
        rand_frame(); cycle(1'b1, 1'b1);
        idle(6, 1'b1);

        // cnt==2: final beat and new capture together -> drop.
        rand_frame(); cycle(1'b1, 1'b0);
        rand_frame(); cycle(1'b1, 1'b0);
        idle(3, 1'b1);
        rand_frame(); cycle(1'b1, 1'b1);
        idle(6, 1'b1);

        // Sequence wrap: back-to-back frames until frame_seq passes 255.
        for (int k = 0; k < 258; k++) begin
            rand_frame();
            cycle(1'b1, 1'b1);
            idle(3, 1'b1);
        end
        idle(4, 1'b1);

        // Random traffic, including NaN/Inf style bit patterns.
        for (int k = 0; k < 2000; k++) begin
            rand_frame();
            if ($urandom_range(0, 7) == 0) re_in[$urandom_range(0, 3)] = 32'h7FC00001;
            if ($urandom_range(0, 7) == 0) im_in[$urandom_range(0, 3)] = 32'hFF800000;
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(12, 1'b1);

        // Reset mid-frame with a second frame queued.
        rand_frame(); cycle(1'b1, 1'b0);
        rand_frame(); cycle(1'b1, 1'b0);
        rand_frame(); cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid_out", 64'(valid_out), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_bin_idx", 64'(bin_idx), 64'd0);
        check("midrst_frame_seq", 64'(frame_seq), 64'd0);
        check("midrst_last", 64'(last), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2, 1'b1);
        rand_frame(); cycle(1'b1, 1'b1);
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
